// File: rtl/vending_pkg.sv
// Shared coin/change codes, FSM state encoding and coin valuation for the vending controller.
package vending_pkg;

  localparam logic [1:0] COIN_NONE  = 2'd0;
  localparam logic [1:0] COIN_TEN   = 2'd1;
  localparam logic [1:0] COIN_FIFTY = 2'd2;

  localparam logic [1:0] CHG_NONE   = 2'd0;
  localparam logic [1:0] CHG_TEN    = 2'd1;
  localparam logic [1:0] CHG_FIFTY  = 2'd2;

  localparam logic [2:0] UNITS_TEN   = 3'd1;
  localparam logic [2:0] UNITS_FIFTY = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  // Credit value of an inserted coin, in 10-dollar units; code 3 counts as no coin.
  function automatic logic [2:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NONE:  return 3'd0;
      COIN_TEN:   return UNITS_TEN;
      COIN_FIFTY: return UNITS_FIFTY;
      default:    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change hopper driver: once started, pays out amount_i one coin per cycle and
// raises done in the first active cycle that finds nothing left to pay.
module change_dispenser import vending_pkg::*; #(
  parameter int CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [CREDIT_W-1:0] amount_i,
  output logic [1:0]          coin_o,
  output logic [CREDIT_W-1:0] pay_o,
  output logic                done_o
);

  logic       active_q, active_d;
  logic [1:0] coin_q, coin_d;

  always_comb begin
    active_d = active_q | start_i;
    coin_d   = CHG_NONE;
    pay_o    = '0;
    done_o   = 1'b0;
    if (active_q) begin
      if (amount_i >= CREDIT_W'(UNITS_FIFTY)) begin
        coin_d = CHG_FIFTY;
        pay_o  = CREDIT_W'(UNITS_FIFTY);
      end else if (amount_i != '0) begin
        coin_d = CHG_TEN;
        pay_o  = CREDIT_W'(UNITS_TEN);
      end else begin
        done_o   = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      coin_q   <= CHG_NONE;
    end else begin
      active_q <= active_d;
      coin_q   <= coin_d;
    end
  end

  assign coin_o = coin_q;

endmodule

// File: rtl/vending_machine_multi.sv
// Vending controller: accumulates coin credit, vends priced items and hands remaining
// credit to the change dispenser. All outputs are registered.
module vending_machine_multi import vending_pkg::*; #(
  parameter int                         N_ITEMS    = 4,
  parameter int                         PRICE_W    = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES     = {4'd10, 4'd7, 4'd5, 4'd2},
  parameter int                         CREDIT_W   = 5,
  parameter int                         MAX_CREDIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [3:0]          sel_idx,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                item_valid,
  output logic [3:0]          item_idx,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                sel_err
);

  // Wide enough for credit + coin and for a zero-extended price of either width.
  localparam int SUM_W = ((PRICE_W > CREDIT_W) ? PRICE_W : CREDIT_W) + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                busy_q, busy_d;
  logic                item_valid_q, item_valid_d;
  logic [3:0]          item_idx_q, item_idx_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_err_q, sel_err_d;

  logic                disp_start;
  logic [CREDIT_W-1:0] disp_pay;
  logic                disp_done;

  logic                coin_in;
  logic                sel_ok;
  logic [SUM_W-1:0]    credit_w, coin_sum, price;

  function automatic logic [SUM_W-1:0] price_of(input logic [3:0] idx);
    logic [SUM_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (idx == 4'(i)) p = SUM_W'(PRICES[i*PRICE_W +: PRICE_W]);
    end
    return p;
  endfunction

  assign coin_in  = (coin_value(coin) != 3'd0);
  assign credit_w = SUM_W'(credit_q);
  assign coin_sum = credit_w + SUM_W'(coin_value(coin));
  assign price    = price_of(sel_idx);
  assign sel_ok   = (int'(sel_idx) < N_ITEMS) && (credit_w >= price);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_valid_d  = 1'b0;
    item_idx_d    = 4'd0;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;
    disp_start    = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          coin_reject_d = coin_in;
          if (credit_q != '0) begin
            state_d    = ST_CHANGE;
            disp_start = 1'b1;
          end
        end else if (sel_valid) begin
          coin_reject_d = coin_in;
          if (!sel_ok) begin
            sel_err_d = 1'b1;
          end else begin
            state_d      = ST_VEND;
            item_valid_d = 1'b1;
            item_idx_d   = sel_idx;
            credit_d     = CREDIT_W'(credit_w - price);
            disp_start   = (credit_w != price);
          end
        end else if (coin_in) begin
          if (coin_sum <= SUM_W'(MAX_CREDIT)) begin
            credit_d = CREDIT_W'(coin_sum);
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_in;
        credit_d      = credit_q - disp_pay;
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        coin_reject_d = coin_in;
        credit_d      = credit_q - disp_pay;
        if (disp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      busy_q        <= 1'b0;
      item_valid_q  <= 1'b0;
      item_idx_q    <= 4'd0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      busy_q        <= busy_d;
      item_valid_q  <= item_valid_d;
      item_idx_q    <= item_idx_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
  end

  change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (disp_start),
    .amount_i (credit_q),
    .coin_o   (change_coin),
    .pay_o    (disp_pay),
    .done_o   (disp_done)
  );

  assign credit      = credit_q;
  assign busy        = busy_q;
  assign item_valid  = item_valid_q;
  assign item_idx    = item_idx_q;
  assign coin_reject = coin_reject_q;
  assign sel_err     = sel_err_q;

endmodule
